// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit, 4-bit-opcode core.
// Define SEQ_PERF_CNT_EN to add the saturating cycle_cnt / instr_cnt performance counters.
module instr_sequencer #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic [15:0]     instr,
  output logic            mem_op,
  output logic            mem_write_en,
  output logic            mem_to_reg,
  output logic            reg_write_en,
  output logic [1:0]      alu_sel,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            retired
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_LS    = 4'h4;
  localparam logic [3:0] OP_CMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  if (PC_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("instr_sequencer: PC_W and CNT_W must be at least 1");
  end

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg;
  logic [15:0]     instr_reg;
  logic [3:0]      opcode;
  logic            imem_req_reg, dmem_req_reg, mem_op_reg, mem_write_en_reg;
  logic            mem_to_reg_reg, reg_write_en_reg, busy_reg, halted_reg;
  logic            illegal_reg, retired_reg;
  logic [1:0]      alu_sel_reg, alu_sel_next;
  logic            illegal_next, retire_next, fetch_done;

  assign opcode     = instr_reg[3:0];
  assign fetch_done = (state_reg == S_FETCH) && imem_req_reg && imem_ack;

  always_comb begin
    state_next   = state_reg;
    illegal_next = 1'b0;
    retire_next  = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: if (fetch_done) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE:              state_next = S_MEM;
          OP_ADD, OP_SUB, OP_LS, OP_CMP:  state_next = S_EXEC;
          OP_HALT: begin
            state_next  = S_HALT;
            retire_next = 1'b1;
          end
          default: begin
            state_next   = S_FETCH;
            illegal_next = 1'b1;
            retire_next  = 1'b1;
          end
        endcase
      end
      S_EXEC: state_next = S_WB;
      S_MEM: begin
        if (dmem_req_reg && dmem_ack) begin
          if (opcode == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            state_next  = S_FETCH;
            retire_next = 1'b1;
          end
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  if (start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_sel_next = 2'b00;
    case (opcode)
      OP_SUB:  alu_sel_next = 2'b01;
      OP_LS:   alu_sel_next = 2'b10;
      OP_CMP:  alu_sel_next = 2'b11;
      default: alu_sel_next = 2'b00;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      pc_reg           <= PC_W'(RESET_PC);
      instr_reg        <= '0;
      imem_req_reg     <= 1'b0;
      dmem_req_reg     <= 1'b0;
      mem_op_reg       <= 1'b0;
      mem_write_en_reg <= 1'b0;
      mem_to_reg_reg   <= 1'b0;
      reg_write_en_reg <= 1'b0;
      alu_sel_reg      <= 2'b00;
      busy_reg         <= 1'b0;
      halted_reg       <= 1'b0;
      illegal_reg      <= 1'b0;
      retired_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (fetch_done) begin
        instr_reg <= imem_rdata;
        pc_reg    <= pc_reg + 1'b1;
      end
      imem_req_reg     <= (state_next == S_FETCH);
      dmem_req_reg     <= (state_next == S_MEM);
      mem_op_reg       <= (state_next == S_MEM);
      mem_write_en_reg <= (state_next == S_MEM) && (opcode == OP_STORE);
      mem_to_reg_reg   <= ((state_next == S_MEM) || (state_next == S_WB)) && (opcode == OP_LOAD);
      reg_write_en_reg <= (state_next == S_WB);
      if (state_next == S_EXEC) alu_sel_reg <= alu_sel_next;
      busy_reg         <= (state_next != S_IDLE) && (state_next != S_HALT);
      halted_reg       <= (state_next == S_HALT);
      illegal_reg      <= illegal_next;
      retired_reg      <= retire_next || (state_next == S_WB);
    end
  end

  assign imem_addr    = pc_reg;
  assign imem_req     = imem_req_reg;
  assign dmem_req     = dmem_req_reg;
  assign instr        = instr_reg;
  assign mem_op       = mem_op_reg;
  assign mem_write_en = mem_write_en_reg;
  assign mem_to_reg   = mem_to_reg_reg;
  assign reg_write_en = reg_write_en_reg;
  assign alu_sel      = alu_sel_reg;
  assign busy         = busy_reg;
  assign halted       = halted_reg;
  assign illegal      = illegal_reg;
  assign retired      = retired_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_reg, instr_cnt_reg;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (busy_reg && !(&cycle_cnt_reg))    cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (retired_reg && !(&instr_cnt_reg)) instr_cnt_reg <= instr_cnt_reg + 1'b1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule
